preload_free_queue: RTL and testbench
=====================================

# preload_free_queue

Parametrised circular free-list queue that comes out of reset, and out of every flush, pre-filled with the identifiers `0, STRIDE, 2*STRIDE, …`. It hands identifiers out through a registered read port plus a combinational peek. Up to two released identifiers are returned per cycle. It is the next-generation branch/CSR tag pool in the issue stage: any depth, any width, dual return port, occupancy counter with no sacrificial slot.

## Interface
Parameters:
- `WIDTH`, default 4: identifier width in bits.
- `DEPTH`, default 4: number of entries; any value ≥ 2, power of two not required.
- `STRIDE`, default 4: preload increment; entry i resets to `(i*STRIDE) mod 2^WIDTH`.

Ports (all synchronous to `Clk`):
- `Clk` in 1: single clock; all state updates on its rising edge.
- `Rest` in 1: reset, synchronous, active-high.
- `Rable` in 1: pop request.
- `Dout` out WIDTH: registered popped identifier.
- `PreOut` out WIDTH: combinational `mem[head]`, valid when `Empty`=0.
- `Wable0` in 1, `Din0` in WIDTH: return port 0; higher priority.
- `Wable1` in 1, `Din1` in WIDTH: return port 1.
- `Clean` in 1: flush; restores the preload state.
- `Full` out 1: `Count == DEPTH`.
- `Empty` out 1: `Count == 0`.
- `Count` out `$clog2(DEPTH+1)`: occupancy.

## Operation
State:
- `mem[0:DEPTH-1]`.
- `head`: read pointer, `$clog2(DEPTH)` bits.
- `tail`: write pointer, `$clog2(DEPTH)` bits.
- `Count`.

Reset (`Rest`=1):
- `mem[i] = i*STRIDE`; `head = 0`; `tail = 0`; `Count = DEPTH`.
- `Dout = 0`; hence `Full = 1`, `Empty = 0`.

Pop:
- `rd_fire = Rable & (Count != 0)`.
- On `rd_fire`: `Dout <= mem[head]`, then `head` advances.
- `Rable` while empty is ignored; `Dout` holds.

Returns:
- `free = DEPTH - Count + rd_fire`.
- `w0_fire = Wable0 & (free >= 1)`.
- `w1_fire = Wable1 & (free >= 1 + w0_fire)`.
- Port 0 writes `mem[tail]`. Port 1 writes `mem[tail + w0_fire]`.
- `tail` advances by `w0_fire + w1_fire`.
- Returns that are not accepted are dropped silently, unless `FREEQ_ERRCHK_EN` is defined (see Configuration).

Counter and pointers:
- `Count <= Count - rd_fire + w0_fire + w1_fire`.
- Pointer arithmetic is modulo `DEPTH`, implemented with an explicit compare-and-wrap, not a power-of-two truncation.

Same-slot collision (full, pop and return in the same cycle, `head == tail`):
- Read-before-write: `Dout` takes the old entry; the slot takes the new value.

Flush (`Clean`=1):
- Overrides pop and returns in that cycle.
- Restores preload contents, pointers and `Count` exactly as reset does.
- `Dout` holds its value.

Priority: `Rest` > `Clean` > normal operation.

## Timing
- Pop latency is 1 cycle: `Dout` is valid on the edge after `Rable`.
- `PreOut` shows the next identifier combinationally, in the same cycle.
- A returned identifier is visible on `PreOut` the cycle after the write when the queue was empty. No write→read bypass exists.
- `Full`, `Empty` and `Count` are derived from registered state only; they carry no combinational path from the inputs.
- Reset mid-operation discards all in-flight state on that edge. The first pop after reset returns 0.

## Configuration
`FREEQ_ERRCHK_EN`:
- When defined, adds output `Err` (out, 1).
- `Err` is sticky. It sets on any of:
  - `Wable0 & ~w0_fire`;
  - `Wable1 & ~w1_fire`;
  - `Rable & Empty`.
- It is cleared only by `Rest`; `Clean` does not clear it.
- When undefined, the port and its logic are absent, and dropped requests are silent.

## Test plan
Defaults `WIDTH=4, DEPTH=4, STRIDE=4`.
1. Reset, then 4 back-to-back pops → `Dout` = 0, 4, 8, 12 on successive cycles; then `Empty=1`, `Count=0`. A fifth pop leaves `Dout=12` (`Err=1` if `FREEQ_ERRCHK_EN`).
2. From empty, return `Din0=7`, `Din1=3` in one cycle → `Count=2`, `PreOut=7`. Pops yield 7, then 3.
3. Full queue, pop plus `Wable0=1` (`Din0=9`) and `Wable1=1` (`Din1=5`) → `Dout=0`. Only 9 is accepted; `Count` stays 4; `Err=1` with the macro.
4. Pop 3 entries, then return 2 per cycle twice → `tail` wraps. After draining, the sequence is 12 followed by the four returned values in order; `Count` never exceeds 4.
5. Pop 2 entries (`Dout=4`), then `Clean` together with `Rable` and `Wable0` → `Count=4`, `PreOut=0`, `Dout` stays 4. The next pops give 0, 4, …
6. `Rest` asserted in the same cycle as a pop and a return → `Dout=0`, `Count=4`, `Err=0`.

Source files
------------

// File: rtl/preload_free_queue.sv
// Circular free-list of identifiers, preloaded with 0, STRIDE, 2*STRIDE, ... on reset and flush.
// Optional sticky drop/underflow flag Err is enabled by defining FREEQ_ERRCHK_EN.
module preload_free_queue #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int STRIDE = 4
) (
  input  logic                       Clk,
  input  logic                       Rest,
  input  logic                       Rable,
  output logic [WIDTH-1:0]           Dout,
  output logic [WIDTH-1:0]           PreOut,
  input  logic                       Wable0,
  input  logic [WIDTH-1:0]           Din0,
  input  logic                       Wable1,
  input  logic [WIDTH-1:0]           Din1,
  input  logic                       Clean,
  output logic                       Full,
  output logic                       Empty,
  output logic [$clog2(DEPTH+1)-1:0] Count
`ifdef FREEQ_ERRCHK_EN
  ,
  output logic                       Err
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] preload [DEPTH];
  logic [PW-1:0]    head_reg, tail_reg;
  logic [PW-1:0]    head_next, tail_next, w1_addr;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] dout_reg;
  logic [CW:0]      free;
  logic             rd_fire, w0_fire, w1_fire;

  // Non-power-of-two depths need an explicit wrap rather than truncation.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_preload
      assign preload[gi] = WIDTH'(gi * STRIDE);
    end
  endgenerate

  assign rd_fire = Rable & (count_reg != '0);
  // A slot vacated by this cycle's pop may be refilled in the same cycle.
  assign free    = (CW+1)'(DEPTH) - {1'b0, count_reg} + {{CW{1'b0}}, rd_fire};
  assign w0_fire = Wable0 & (free != '0);
  assign w1_fire = Wable1 & (free > {{CW{1'b0}}, w0_fire});
  assign w1_addr = w0_fire ? ptr_inc(tail_reg) : tail_reg;

  always_comb begin
    head_next = rd_fire ? ptr_inc(head_reg) : head_reg;
    tail_next = tail_reg;
    if (w0_fire && w1_fire)
      tail_next = ptr_inc(ptr_inc(tail_reg));
    else if (w0_fire || w1_fire)
      tail_next = ptr_inc(tail_reg);
    count_next = count_reg - CW'(rd_fire) + CW'(w0_fire) + CW'(w1_fire);
  end

  always_ff @(posedge Clk) begin
    if (Rest || Clean) begin
      for (int i = 0; i < DEPTH; i++)
        mem_reg[i] <= preload[i];
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= CW'(DEPTH);
      if (Rest)
        dout_reg <= '0;
    end else begin
      // Read-before-write: a pop and a return to the same slot see the old entry.
      if (rd_fire)
        dout_reg <= mem_reg[head_reg];
      if (w0_fire)
        mem_reg[tail_reg] <= Din0;
      if (w1_fire)
        mem_reg[w1_addr] <= Din1;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

`ifdef FREEQ_ERRCHK_EN
  logic err_reg;
  always_ff @(posedge Clk) begin
    if (Rest)
      err_reg <= 1'b0;
    else if ((Wable0 & ~w0_fire) | (Wable1 & ~w1_fire) | (Rable & Empty))
      err_reg <= 1'b1;
  end
  assign Err = err_reg;
`endif

  assign Dout   = dout_reg;
  assign PreOut = mem_reg[head_reg];
  assign Count  = count_reg;
  assign Full   = (count_reg == CW'(DEPTH));
  assign Empty  = (count_reg == '0);

endmodule

// File: tb/tb_preload_free_queue.sv
// Directed self-checking bench for preload_free_queue at WIDTH=4, DEPTH=4, STRIDE=4.
module tb_preload_free_queue;

  logic       Clk = 1'b0;
  logic       Rest = 1'b1, Rable = 1'b0, Wable0 = 1'b0, Wable1 = 1'b0, Clean = 1'b0;
  logic [3:0] Din0 = '0, Din1 = '0;
  logic [3:0] Dout, PreOut;
  logic       Full, Empty;
  logic [2:0] Count;
`ifdef FREEQ_ERRCHK_EN
  logic       Err;
`endif

  int checks = 0;
  int failures = 0;

  preload_free_queue #(.WIDTH(4), .DEPTH(4), .STRIDE(4)) dut (
    .Clk(Clk), .Rest(Rest), .Rable(Rable), .Dout(Dout), .PreOut(PreOut),
    .Wable0(Wable0), .Din0(Din0), .Wable1(Wable1), .Din1(Din1),
    .Clean(Clean), .Full(Full), .Empty(Empty), .Count(Count)
`ifdef FREEQ_ERRCHK_EN
    , .Err(Err)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    tick();
    Rest = 1'b0;
    chk("rst_count", 8'(Count), 8'd4);
    chk("rst_full", 8'(Full), 8'd1);
    chk("rst_empty", 8'(Empty), 8'd0);
    chk("rst_dout", 8'(Dout), 8'd0);
    chk("rst_preout", 8'(PreOut), 8'd0);
`ifdef FREEQ_ERRCHK_EN
    chk("rst_err", 8'(Err), 8'd0);
`endif

    // 1: drain the preload, then pop while empty
    Rable = 1'b1;
    tick(); chk("t1_pop0", 8'(Dout), 8'd0);
    chk("t1_preout", 8'(PreOut), 8'd4);
    tick(); chk("t1_pop1", 8'(Dout), 8'd4);
    tick(); chk("t1_pop2", 8'(Dout), 8'd8);
    tick(); chk("t1_pop3", 8'(Dout), 8'd12);
    chk("t1_empty", 8'(Empty), 8'd1);
    chk("t1_count", 8'(Count), 8'd0);
    tick(); chk("t1_underflow", 8'(Dout), 8'd12);
    chk("t1_count_uf", 8'(Count), 8'd0);
`ifdef FREEQ_ERRCHK_EN
    chk("t1_err", 8'(Err), 8'd1);
`endif
    Rable = 1'b0;

    // 2: dual return into an empty queue
    Wable0 = 1'b1; Din0 = 4'd7; Wable1 = 1'b1; Din1 = 4'd3;
    tick();
    Wable0 = 1'b0; Wable1 = 1'b0;
    chk("t2_count", 8'(Count), 8'd2);
    chk("t2_preout", 8'(PreOut), 8'd7);
    Rable = 1'b1;
    tick(); chk("t2_pop0", 8'(Dout), 8'd7);
    tick(); chk("t2_pop1", 8'(Dout), 8'd3);
    chk("t2_empty", 8'(Empty), 8'd1);
    Rable = 1'b0;

    // 3: full queue, pop plus two returns; only port 0 fits, same-slot read-before-write
    Rest = 1'b1; tick(); Rest = 1'b0;
    Rable = 1'b1; Wable0 = 1'b1; Din0 = 4'd9; Wable1 = 1'b1; Din1 = 4'd5;
    tick();
    Wable0 = 1'b0; Wable1 = 1'b0;
    chk("t3_dout", 8'(Dout), 8'd0);
    chk("t3_count", 8'(Count), 8'd4);
`ifdef FREEQ_ERRCHK_EN
    chk("t3_err", 8'(Err), 8'd1);
`endif
    tick(); chk("t3_pop1", 8'(Dout), 8'd4);
    tick(); chk("t3_pop2", 8'(Dout), 8'd8);
    tick(); chk("t3_pop3", 8'(Dout), 8'd12);
    tick(); chk("t3_pop4", 8'(Dout), 8'd9);
    chk("t3_empty", 8'(Empty), 8'd1);
    Rable = 1'b0;

    // 4: tail wrap with pop overlapping the first pair of returns
    Rest = 1'b1; tick(); Rest = 1'b0;
    Rable = 1'b1;
    tick(); tick(); tick();
    chk("t4_dout3", 8'(Dout), 8'd8);
    chk("t4_count1", 8'(Count), 8'd1);
    Wable0 = 1'b1; Din0 = 4'd1; Wable1 = 1'b1; Din1 = 4'd2;
    tick();
    chk("t4_pop12", 8'(Dout), 8'd12);
    chk("t4_count2", 8'(Count), 8'd2);
    Rable = 1'b0; Din0 = 4'd3; Din1 = 4'd5;
    tick();
    Wable0 = 1'b0; Wable1 = 1'b0;
    chk("t4_count4", 8'(Count), 8'd4);
    chk("t4_full", 8'(Full), 8'd1);
    chk("t4_preout", 8'(PreOut), 8'd1);
    Rable = 1'b1;
    tick(); chk("t4_pop_a", 8'(Dout), 8'd1);
    tick(); chk("t4_pop_b", 8'(Dout), 8'd2);
    tick(); chk("t4_pop_c", 8'(Dout), 8'd3);
    tick(); chk("t4_pop_d", 8'(Dout), 8'd5);
    chk("t4_empty", 8'(Empty), 8'd1);
    Rable = 1'b0;

    // 5: flush overrides a concurrent pop and return; Dout holds
    Rest = 1'b1; tick(); Rest = 1'b0;
    Rable = 1'b1;
    tick(); tick();
    chk("t5_dout", 8'(Dout), 8'd4);
    Clean = 1'b1; Wable0 = 1'b1; Din0 = 4'd11;
    tick();
    Clean = 1'b0; Wable0 = 1'b0;
    chk("t5_count", 8'(Count), 8'd4);
    chk("t5_preout", 8'(PreOut), 8'd0);
    chk("t5_dout_hold", 8'(Dout), 8'd4);
    tick(); chk("t5_pop0", 8'(Dout), 8'd0);
    tick(); chk("t5_pop1", 8'(Dout), 8'd4);
    Rable = 1'b0;

    // 6: reset wins over a pop and a return in the same cycle
    Rable = 1'b1; Wable0 = 1'b1; Din0 = 4'd13; Rest = 1'b1;
    tick();
    Rest = 1'b0; Wable0 = 1'b0; Rable = 1'b0;
    chk("t6_dout", 8'(Dout), 8'd0);
    chk("t6_count", 8'(Count), 8'd4);
    chk("t6_preout", 8'(PreOut), 8'd0);
`ifdef FREEQ_ERRCHK_EN
    chk("t6_err", 8'(Err), 8'd0);
`endif
    Rable = 1'b1;
    tick(); chk("t6_pop0", 8'(Dout), 8'd0);
    chk("t6_count3", 8'(Count), 8'd3);
    Rable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
